// File: rtl/rv2t_machine_timer_if.sv
// ---------------------------------------------------------------------------
// rv2t_machine_timer_if
//   Data-memory peripheral bus as seen by the machine timer.
//   master : CPU side, drives the strobes, address and write data
//   slave  : timer side, returns the read ack and the read data
//   mem_read_enable  1   read strobe, one cycle per access
//   mem_write_enable 1   write strobe, one cycle per access
//   mem_addr         2   word index (0 mtime_lo, 1 mtime_hi, 2 cmp_lo, 3 cmp_hi)
//   mem_write_data   32  write data
//   mem_read_ack     1   high the cycle after mem_read_enable
//   mem_read_data    32  read data, held while mem_read_ack is low
// ---------------------------------------------------------------------------
interface rv2t_machine_timer_if;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [1:0]  mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read_ack;
    logic [31:0] mem_read_data;

    modport master (
        output mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
        input  mem_read_ack, mem_read_data
    );

    modport slave (
        input  mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
        output mem_read_ack, mem_read_data
    );
endinterface

// File: rtl/rv2t_machine_timer.sv
// ---------------------------------------------------------------------------
// rv2t_machine_timer
//   RISC-V machine timer: free-running 64-bit mtime advanced every PRESCALE
//   clocks, 64-bit mtimecmp, and a registered level timer_triggered
//   (mtime >= mtimecmp) for the CSR block to edge-detect.
//   clk             in   single clock, rising edge
//   reset           in   asynchronous active-high reset
//   sync_reset      in   synchronous reset, same effect as reset
//   bus             slave modport of rv2t_machine_timer_if (32-bit window)
//   timer_triggered out  registered unsigned compare mtime >= mtimecmp
// ---------------------------------------------------------------------------
module rv2t_machine_timer #(
    parameter int XLEN     = 32,
    parameter int PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sync_reset,
    rv2t_machine_timer_if.slave  bus,
    output logic                 timer_triggered
);
    localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0]   r_presc;
    logic [63:0]     r_mtime;
    logic [63:0]     r_cmp;
    logic [XLEN-1:0] r_shadow;
    logic            r_ack;
    logic [XLEN-1:0] r_rdata;
    logic            r_trig;

    logic            w_tick;
    logic [PW-1:0]   w_presc_next;
    logic [63:0]     w_mtime_next;
    logic [63:0]     w_cmp_next;
    logic [XLEN-1:0] w_rdata;

    always_comb begin
        w_tick       = (r_presc == PRESC_MAX);
        w_presc_next = w_tick ? '0 : r_presc + PW'(1);
        w_mtime_next = w_tick ? r_mtime + 64'd1 : r_mtime;
        w_cmp_next   = r_cmp;
        // An mtime write starts from the un-incremented value, so a tick in
        // the same cycle is dropped entirely (including any carry).
        if (bus.mem_write_enable) begin
            case (bus.mem_addr)
                2'd0: begin
                    w_mtime_next = {r_mtime[63:XLEN], bus.mem_write_data};
                    w_presc_next = '0;
                end
                2'd1: begin
                    w_mtime_next = {bus.mem_write_data, r_mtime[XLEN-1:0]};
                    w_presc_next = '0;
                end
                2'd2:    w_cmp_next = {r_cmp[63:XLEN], bus.mem_write_data};
                default: w_cmp_next = {bus.mem_write_data, r_cmp[XLEN-1:0]};
            endcase
        end
    end

    // Reads see pre-write state; hi half of mtime comes from the shadow
    // captured by the preceding lo read so a lo/hi pair is coherent.
    always_comb begin
        case (bus.mem_addr)
            2'd0:    w_rdata = r_mtime[XLEN-1:0];
            2'd1:    w_rdata = r_shadow;
            2'd2:    w_rdata = r_cmp[XLEN-1:0];
            default: w_rdata = r_cmp[63:XLEN];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc  <= '0;
            r_mtime  <= '0;
            r_cmp    <= '1;
            r_shadow <= '0;
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_trig   <= 1'b0;
        end else if (sync_reset) begin
            r_presc  <= '0;
            r_mtime  <= '0;
            r_cmp    <= '1;
            r_shadow <= '0;
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_trig   <= 1'b0;
        end else begin
            r_presc <= w_presc_next;
            r_mtime <= w_mtime_next;
            r_cmp   <= w_cmp_next;
            r_ack   <= bus.mem_read_enable;
            if (bus.mem_read_enable) begin
                r_rdata <= w_rdata;
                if (bus.mem_addr == 2'd0)
                    r_shadow <= r_mtime[63:XLEN];
            end
            // Compare on post-update values.
            r_trig <= (w_mtime_next >= w_cmp_next);
        end
    end

    assign bus.mem_read_ack  = r_ack;
    assign bus.mem_read_data = r_rdata;
    assign timer_triggered   = r_trig;
endmodule

// File: tb/tb_rv2t_machine_timer.sv
module tb_rv2t_machine_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        srst = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        trig0, trig1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rv2t_machine_timer_if if0 ();
    rv2t_machine_timer_if if1 ();

    assign if0.mem_read_enable  = rd_en;
    assign if0.mem_write_enable = wr_en;
    assign if0.mem_addr         = addr;
    assign if0.mem_write_data   = wdata;
    assign if1.mem_read_enable  = rd_en;
    assign if1.mem_write_enable = wr_en;
    assign if1.mem_addr         = addr;
    assign if1.mem_write_data   = wdata;

    rv2t_machine_timer #(.XLEN(32), .PRESCALE(1)) u_dut0 (
        .clk(clk), .reset(rst), .sync_reset(srst), .bus(if0), .timer_triggered(trig0));
    rv2t_machine_timer #(.XLEN(32), .PRESCALE(4)) u_dut1 (
        .clk(clk), .reset(rst), .sync_reset(srst), .bus(if1), .timer_triggered(trig1));

    // Reference model: mtime = base + (cycles since base was set) / PRESCALE.
    longint unsigned PRE [2] = '{64'd1, 64'd4};
    longint unsigned m_base [2];
    longint unsigned m_el [2];
    logic [63:0]     m_cmp [2];
    logic [31:0]     m_shadow [2];
    logic [31:0]     m_data [2];
    logic            m_ack [2];
    logic            m_trig [2];
    logic [63:0]     cur, nt, nc, after;
    bit              wm;

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || srst) begin
                m_base[k] = 0; m_el[k] = 0; m_cmp[k] = '1; m_shadow[k] = 0;
                m_data[k] = 0; m_ack[k] = 0; m_trig[k] = 0;
            end else begin
                cur = m_base[k] + m_el[k] / PRE[k];
                nt = cur; nc = m_cmp[k]; wm = 0;
                m_ack[k] = rd_en;
                if (rd_en) begin
                    case (addr)
                        2'd0: begin m_data[k] = cur[31:0]; end
                        2'd1: m_data[k] = m_shadow[k];
                        2'd2: m_data[k] = m_cmp[k][31:0];
                        default: m_data[k] = m_cmp[k][63:32];
                    endcase
                    if (addr == 2'd0) m_shadow[k] = cur[63:32];
                end
                if (wr_en) begin
                    case (addr)
                        2'd0: begin nt = {cur[63:32], wdata}; wm = 1; end
                        2'd1: begin nt = {wdata, cur[31:0]}; wm = 1; end
                        2'd2: nc = {m_cmp[k][63:32], wdata};
                        default: nc = {wdata, m_cmp[k][31:0]};
                    endcase
                end
                if (wm) begin m_base[k] = nt; m_el[k] = 0; end
                else m_el[k] = m_el[k] + 1;
                m_cmp[k] = nc;
                after = m_base[k] + m_el[k] / PRE[k];
                m_trig[k] = (after >= m_cmp[k]);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("dut0 ack",  64'(if0.mem_read_ack),  64'(m_ack[0]));
        chk("dut0 data", 64'(if0.mem_read_data), 64'(m_data[0]));
        chk("dut0 trig", 64'(trig0),             64'(m_trig[0]));
        chk("dut1 ack",  64'(if1.mem_read_ack),  64'(m_ack[1]));
        chk("dut1 data", 64'(if1.mem_read_data), 64'(m_data[1]));
        chk("dut1 trig", 64'(trig1),             64'(m_trig[1]));
    end

    // All tasks are entered and left at 1 time unit after a rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        rd_en = 1'b1; addr = a;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 5)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'hFFFF_FFFE;
            3: return 32'($urandom % 32);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("reset trig", 64'(trig0), 64'd0);

        // Reset values
        rd(2'd2);
        chk("reset cmp_lo ack", 64'(if0.mem_read_ack), 64'd1);
        chk("reset cmp_lo", 64'(if0.mem_read_data), 64'hFFFF_FFFF);
        rd(2'd0);
        chk("reset mtime_lo", 64'(if0.mem_read_data), 64'd1);
        chk("reset mtime_lo p4", 64'(if1.mem_read_data), 64'd0);

        // Prescale
        wr(2'd1, 32'd0); wr(2'd0, 32'd0);
        idle(40);
        rd(2'd0);
        chk("prescale p4 after 40", 64'(if1.mem_read_data), 64'd10);
        chk("prescale p1 after 40", 64'(if0.mem_read_data), 64'd40);

        // Compare rise and fall
        wr(2'd0, 32'd0); wr(2'd3, 32'd0); wr(2'd2, 32'd20);
        idle(17);
        chk("cmp trig at 19", 64'(trig0), 64'd0);
        idle(1);
        chk("cmp trig at 20", 64'(trig0), 64'd1);
        wr(2'd2, 32'd1000);
        chk("cmp trig drop", 64'(trig0), 64'd0);

        // Carry and shadow coherence
        wr(2'd1, 32'd0); wr(2'd0, 32'hFFFF_FFFE);
        idle(1);
        rd(2'd0);
        chk("carry lo", 64'(if0.mem_read_data), 64'hFFFF_FFFF);
        rd(2'd1);
        chk("carry hi shadow", 64'(if0.mem_read_data), 64'd0);

        // Wrap
        wr(2'd3, 32'd0); wr(2'd2, 32'd0);
        wr(2'd1, 32'hFFFF_FFFF); wr(2'd0, 32'hFFFF_FFFF);
        chk("wrap trig max", 64'(trig0), 64'd1);
        rd(2'd0);
        chk("wrap lo max", 64'(if0.mem_read_data), 64'hFFFF_FFFF);
        chk("wrap trig 0", 64'(trig0), 64'd1);
        rd(2'd0);
        chk("wrap lo 0", 64'(if0.mem_read_data), 64'd0);
        rd(2'd1);
        chk("wrap hi 0", 64'(if0.mem_read_data), 64'd0);
        chk("wrap trig 1", 64'(trig0), 64'd1);

        // Collision: mtime write on a tick cycle of the PRESCALE=4 timer
        wr(2'd3, 32'd0); wr(2'd2, 32'd6);
        wr(2'd1, 32'd0); wr(2'd0, 32'd100);
        idle(3);
        wr(2'd0, 32'd5);
        chk("collision trig after write", 64'(trig1), 64'd0);
        idle(3);
        chk("collision still 5", 64'(trig1), 64'd0);
        idle(1);
        chk("collision reaches 6", 64'(trig1), 64'd1);
        rd(2'd0);
        chk("collision readback 6", 64'(if1.mem_read_data), 64'd6);

        // Async reset in the middle of a read access
        rd_en = 1'b1; addr = 2'd2;
        #3 rst = 1'b1;
        #1;
        chk("async ack", 64'(if0.mem_read_ack), 64'd0);
        chk("async data", 64'(if1.mem_read_data), 64'd0);
        chk("async trig", 64'(trig1), 64'd0);
        rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        rd(2'd2);
        chk("post reset cmp", 64'(if1.mem_read_data), 64'hFFFF_FFFF);

        // Synchronous reset
        wr(2'd2, 32'd7);
        srst = 1'b1; idle(1); srst = 1'b0;
        rd(2'd2);
        chk("sync reset cmp", 64'(if0.mem_read_data), 64'hFFFF_FFFF);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rd_en = ($urandom % 3) == 0;
            wr_en = ($urandom % 4) == 0;
            addr  = 2'($urandom % 4);
            wdata = pick();
            srst  = ($urandom % 80) == 0;
            @(posedge clk); #1;
        end
        rd_en = 1'b0; wr_en = 1'b0; srst = 1'b0;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
